cmp_max_tracker: RTL

- Streaming consumer of the 32-bit greater-than comparator result.
- Accepts a frame of unsigned 32-bit samples over a valid/ready handshake and tracks the running maximum, its index and the sample count.
- Presents one result per frame on an output handshake.
- Drives the comparator operands itself (cmp_a = incoming sample, cmp_b = current max) and consumes its 1-bit result in the same cycle.

---
 rtl/cmp_pkg.sv | 19 +
 rtl/cmp_track_slot.sv | 64 ++++++
 rtl/cmp_max_tracker.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg
//   Shared definitions for the max/min tracker slice: default widths, the
//   frame FSM state encoding and the default saturating count limit.
//   No ports.
package cmp_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    // All-ones count for the default counter width.
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_track_slot.sv
// cmp_track_slot
//   Holds one tracked extreme (value + index of first occurrence).
//   Priority: clear > seed > take. Exposes the next-state values so the
//   parent can capture a frame result that includes the final sample.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           drop the tracked value (end of frame)
//   seed            first sample of a frame: load value, index 0
//   take            replace with value/index (strict comparator win)
//   value, index    candidate sample and its position
//   val_q, idx_q    registered tracked value and index
//   val_next        next-state value (combinational)
//   idx_next        next-state index (combinational)
import cmp_pkg::*;

module cmp_track_slot #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              seed,
    input  logic              take,
    input  logic [DATA_W-1:0] value,
    input  logic [CNT_W-1:0]  index,
    output logic [DATA_W-1:0] val_q,
    output logic [CNT_W-1:0]  idx_q,
    output logic [DATA_W-1:0] val_next,
    output logic [CNT_W-1:0]  idx_next
);

    logic [DATA_W-1:0] val_reg;
    logic [CNT_W-1:0]  idx_reg;

    always_comb begin
        val_next = val_reg;
        idx_next = idx_reg;
        if (clear) begin
            val_next = '0;
            idx_next = '0;
        end else if (seed) begin
            val_next = value;
            idx_next = '0;
        end else if (take) begin
            val_next = value;
            idx_next = index;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_reg <= '0;
            idx_reg <= '0;
        end else begin
            val_reg <= val_next;
            idx_reg <= idx_next;
        end
    end

    assign val_q = val_reg;
    assign idx_q = idx_reg;

endmodule

// File: rtl/cmp_max_tracker.sv
// cmp_max_tracker
//   Streams a frame of unsigned samples in over a valid/ready handshake and
//   reports the frame maximum, the index of its first occurrence and the
//   (saturating) sample count over an output handshake. The greater-than
//   decision comes from an external comparator driven by this block
//   (cmp_a = in_data, cmp_b = current max) and is used in the same cycle.
//   Optional minimum tracking is built when CMP_MAX_TRACKER_MIN_EN is defined.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            input handshake
//   in_data, in_last             sample and end-of-frame marker
//   cmp_a, cmp_b, cmp_gt         external comparator (cmp_a > cmp_b)
//   out_valid/out_ready          result handshake
//   out_max, out_idx             frame maximum and its first index
//   out_count, out_sat           sample count (saturating) and sticky flag
//   [MIN_EN] cmp2_a, cmp2_b, cmp2_gt   second comparator (min_q > in_data)
//   [MIN_EN] out_min, out_min_idx      frame minimum and its first index
import cmp_pkg::*;

module cmp_max_tracker #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [DATA_W-1:0] cmp_a,
    output logic [DATA_W-1:0] cmp_b,
    input  logic              cmp_gt,
`ifdef CMP_MAX_TRACKER_MIN_EN
    output logic [DATA_W-1:0] cmp2_a,
    output logic [DATA_W-1:0] cmp2_b,
    input  logic              cmp2_gt,
    output logic [DATA_W-1:0] out_min,
    output logic [CNT_W-1:0]  out_min_idx,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_idx,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    // Saturation limit for this instance's counter width.
    localparam logic [CNT_W-1:0] CNT_ALL = {CNT_W{1'b1}};

    state_t            state_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_max_reg;
    logic [CNT_W-1:0]  out_idx_reg;
    logic [CNT_W-1:0]  out_count_reg;
    logic              out_sat_reg;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              sat_reg, sat_next;

    logic              accept;
    logic              seed;
    logic              in_accum;
    logic              clear;
    logic              frame_end;

    logic [DATA_W-1:0] max_q, max_next;
    logic [CNT_W-1:0]  idx_q, idx_next;

    assign accept    = in_valid & in_ready_reg;
    assign seed      = accept & (state_reg == IDLE);
    assign in_accum  = accept & (state_reg == ACCUM);
    assign clear     = out_valid_reg & out_ready & (state_reg == DONE);
    assign frame_end = accept & in_last;

    // cmp_gt is only meaningful while a sample is being accepted in ACCUM.
    cmp_track_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_max (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .seed     (seed),
        .take     (in_accum & cmp_gt),
        .value    (in_data),
        .index    (cnt_reg),
        .val_q    (max_q),
        .idx_q    (idx_q),
        .val_next (max_next),
        .idx_next (idx_next)
    );

    assign cmp_a = in_data;
    assign cmp_b = max_q;

`ifdef CMP_MAX_TRACKER_MIN_EN
    logic [DATA_W-1:0] min_q, min_next;
    logic [CNT_W-1:0]  min_idx_q, min_idx_next;
    logic [DATA_W-1:0] out_min_reg;
    logic [CNT_W-1:0]  out_min_idx_reg;

    cmp_track_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_min (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .seed     (seed),
        .take     (in_accum & cmp2_gt),
        .value    (in_data),
        .index    (cnt_reg),
        .val_q    (min_q),
        .idx_q    (min_idx_q),
        .val_next (min_next),
        .idx_next (min_idx_next)
    );

    assign cmp2_a      = min_q;
    assign cmp2_b      = in_data;
    assign out_min     = out_min_reg;
    assign out_min_idx = out_min_idx_reg;
`endif

    // Count and sticky saturation flag. Index capture uses cnt_reg, which
    // is already the saturated value once the counter has topped out.
    always_comb begin
        cnt_next = cnt_reg;
        sat_next = sat_reg;
        if (clear) begin
            cnt_next = '0;
            sat_next = 1'b0;
        end else if (seed) begin
            cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
            sat_next = 1'b0;
        end else if (in_accum) begin
            if (cnt_reg == CNT_ALL) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_max_reg   <= '0;
            out_idx_reg   <= '0;
            out_count_reg <= '0;
            out_sat_reg   <= 1'b0;
            cnt_reg       <= '0;
            sat_reg       <= 1'b0;
`ifdef CMP_MAX_TRACKER_MIN_EN
            out_min_reg     <= '0;
            out_min_idx_reg <= '0;
`endif
        end else begin
            cnt_reg <= cnt_next;
            sat_reg <= sat_next;
            case (state_reg)
                IDLE: begin
                    if (accept) state_reg <= in_last ? DONE : ACCUM;
                end
                ACCUM: begin
                    if (frame_end) state_reg <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
            // Results are captured from the next-state values so the final
            // sample's update is included on the DONE entry edge.
            if (frame_end) begin
                out_valid_reg <= 1'b1;
                in_ready_reg  <= 1'b0;
                out_max_reg   <= max_next;
                out_idx_reg   <= idx_next;
                out_count_reg <= cnt_next;
                out_sat_reg   <= sat_next;
`ifdef CMP_MAX_TRACKER_MIN_EN
                out_min_reg     <= min_next;
                out_min_idx_reg <= min_idx_next;
`endif
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_max   = out_max_reg;
    assign out_idx   = out_idx_reg;
    assign out_count = out_count_reg;
    assign out_sat   = out_sat_reg;

endmodule
